// File: rtl/bidir_pio_ex.sv
// bidir_pio_ex: Avalon-MM slave bidirectional parallel I/O port, WIDTH pins.
//   Per-bit direction, synchronised input path, atomic set/clear of data_out,
//   per-bit edge capture with maskable level interrupt. Read latency 1 cycle.
// Ports: clk/reset_n (async active-low), Avalon slave (address, chipselect,
//   write_n, read_n, writedata, readdata), irq (active high), bidir_port pins.
// Build option: define BIDIR_PIO_OPEN_DRAIN_EN for open-drain pin drive
//   (drive 0 or release); default build is push-pull.
// Register map: 0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP (W1C), 4 OUTSET, 5 OUTCLR,
//   6/7 reserved (read 0, writes ignored).
module bidir_pio_ex #(
  parameter int              WIDTH       = 8,
  parameter int              SYNC_STAGES = 2,
  parameter int              EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_OUT  = '0,
  parameter logic [WIDTH-1:0] RESET_DIR  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_DIR     = 3'd1;
  localparam logic [2:0] A_IRQMASK = 3'd2;
  localparam logic [2:0] A_EDGECAP = 3'd3;
  localparam logic [2:0] A_OUTSET  = 3'd4;
  localparam logic [2:0] A_OUTCLR  = 3'd5;

  logic [WIDTH-1:0]                  out_q,   out_d;
  logic [WIDTH-1:0]                  dir_q,   dir_d;
  logic [WIDTH-1:0]                  mask_q,  mask_d;
  logic [WIDTH-1:0]                  cap_q,   cap_d;
  logic [WIDTH-1:0]                  rdata_q, rdata_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q,  sync_d;
  logic [WIDTH-1:0]                  prev_q,  prev_d;
  logic [ARM_W-1:0]                  arm_q,   arm_d;

  logic             wr_en;
  logic             rd_en;
  logic             armed;
  logic [WIDTH-1:0] pin_sync;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] cap_clr;

  assign wr_en    = chipselect & ~write_n;
  assign rd_en    = chipselect & ~read_n;
  assign pin_sync = sync_q[SYNC_STAGES-1];
  // Disarmed until the synchroniser and previous flop hold real pin values,
  // so static pin levels present at reset release never look like edges.
  assign armed    = (arm_q == ARM_W'(ARM_CYCLES));

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bidir_port;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d = pin_sync;
    arm_d  = armed ? arm_q : arm_q + ARM_W'(1);
  end

  always_comb begin
    case (EDGE_TYPE)
      1:       edge_raw = ~pin_sync &  prev_q;
      2:       edge_raw =  pin_sync ^  prev_q;
      default: edge_raw =  pin_sync & ~prev_q;
    endcase
  end

  // Register writes; OUTSET/OUTCLR are single-cycle read-modify-write of out_q.
  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    mask_d  = mask_q;
    cap_clr = '0;
    if (wr_en) begin
      case (address)
        A_DATA:    out_d   = writedata;
        A_DIR:     dir_d   = writedata;
        A_IRQMASK: mask_d  = writedata;
        A_EDGECAP: cap_clr = writedata;
        A_OUTSET:  out_d   = out_q | writedata;
        A_OUTCLR:  out_d   = out_q & ~writedata;
        default:   ;
      endcase
    end
    // A new edge beats a simultaneous write-1-clear of the same bit.
    cap_d = (cap_q & ~cap_clr) | (armed ? edge_raw : '0);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (address)
        A_DATA:    rdata_d = pin_sync;
        A_DIR:     rdata_d = dir_q;
        A_IRQMASK: rdata_d = mask_q;
        A_EDGECAP: rdata_d = cap_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= RESET_OUT;
      dir_q   <= RESET_DIR;
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      arm_q   <= arm_d;
    end
  end

  assign readdata = rdata_q;
  // Built only from registers, so address decode cannot glitch irq.
  assign irq      = |(cap_q & mask_q);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
`ifdef BIDIR_PIO_OPEN_DRAIN_EN
    // data_out 1 releases the line; external pull-up supplies the high level.
    assign bidir_port[i] = (dir_q[i] & ~out_q[i]) ? 1'b0 : 1'bz;
`else
    assign bidir_port[i] = dir_q[i] ? out_q[i] : 1'bz;
`endif
  end

endmodule

// File: tb/tb_bidir_pio_ex.sv
// Testbench for bidir_pio_ex (WIDTH 8, SYNC_STAGES 2, rising edge capture).
// Expected read data is queued when a read is issued and checked when
// readdata becomes valid one cycle later.
module tb_bidir_pio_ex;

  logic       clk;
  logic       reset_n;
  logic [2:0] address;
  logic       chipselect;
  logic       write_n;
  logic       read_n;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       irq;
  wire  [7:0] pins;

  logic [7:0] tb_en;
  logic [7:0] tb_val;

  int n_assert;
  int n_fail;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  for (genvar i = 0; i < 8; i++) begin : g_drv
    assign pins[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  bidir_pio_ex #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .EDGE_TYPE  (0),
    .RESET_OUT  (8'h00),
    .RESET_DIR  (8'h00)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .read_n    (read_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .bidir_port(pins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    tick();
    chipselect = 1'b0;
    read_n     = 1'b1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {24'h0, readdata}, {24'h0, e});
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    writedata  = 8'h00;
    tb_en      = 8'hFF;
    tb_val     = 8'hA5;

    // Reset with pins held at 0xA5.
    repeat (3) tick();
    chk("rst_readdata", {24'h0, readdata}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    repeat (4) tick();
    rd(3'd3, 8'h00, "edgecap_after_arm");
    rd(3'd0, 8'hA5, "data_reset_pins");
    chk("irq_after_arm", {31'h0, irq}, 32'h0);

    // Low nibble driven by DUT, high nibble by bench; back-to-back writes.
    tb_en  = 8'hF0;
    tb_val = 8'h40;
    wr(3'd1, 8'h0F);
    wr(3'd0, 8'h3C);
    wr(3'd4, 8'h81);
    wr(3'd5, 8'h04);
    rd(3'd1, 8'h0F, "dir_readback");
    repeat (3) tick();
    chk("pins_low_nibble", {28'h0, pins[3:0]}, 32'h9);
    rd(3'd0, 8'h49, "data_loopback_mixed");
    tb_en = 8'h00;
    wr(3'd1, 8'hFF);
    repeat (3) tick();
    rd(3'd0, 8'hB9, "data_out_full");

    // Back to all-input, clear stale captures.
    wr(3'd1, 8'h00);
    tb_en  = 8'hFF;
    tb_val = 8'h00;
    repeat (4) tick();
    wr(3'd3, 8'hFF);
    rd(3'd3, 8'h00, "edgecap_cleared");

    // Rising edge on pin1 with IRQMASK=0x02.
    wr(3'd2, 8'h02);
    rd(3'd2, 8'h02, "irqmask_readback");
    tick();
    chk("readdata_hold", {24'h0, readdata}, 32'h02);
    tb_val = 8'h02;
    tick();
    rd(3'd0, 8'h00, "data_before_sync_done");
    chk("irq_before_capture", {31'h0, irq}, 32'h0);
    rd(3'd0, 8'h02, "data_after_sync");
    chk("irq_on_capture", {31'h0, irq}, 32'h1);
    rd(3'd3, 8'h02, "edgecap_pin1");
    wr(3'd3, 8'h02);
    chk("irq_cleared", {31'h0, irq}, 32'h0);

    // Falling edge is not captured in rising mode.
    tb_val = 8'h00;
    repeat (4) tick();
    rd(3'd3, 8'h00, "no_fall_capture");

    // Rising edge on pin3 coincident with write-1-clear of bit 3.
    tb_val = 8'h08;
    tick();
    tick();
    wr(3'd3, 8'h08);
    rd(3'd3, 8'h08, "edge_wins_over_clear");
    chk("irq_masked_bit3", {31'h0, irq}, 32'h0);
    wr(3'd3, 8'h08);
    rd(3'd3, 8'h00, "cap3_cleared");

    // Reserved / write-only addresses.
    rd(3'd6, 8'h00, "addr6_reads_zero");
    rd(3'd4, 8'h00, "outset_reads_zero");
    wr(3'd7, 8'hFF);
    rd(3'd1, 8'h00, "dir_after_addr7_write");

    // Reset asserted mid-operation.
    tb_val = 8'h0A;
    repeat (4) tick();
    chk("irq_pre_reset", {31'h0, irq}, 32'h1);
    rd(3'd2, 8'h02, "mask_pre_reset");
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_readdata", {24'h0, readdata}, 32'h0);
    chk("midreset_irq", {31'h0, irq}, 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    rd(3'd2, 8'h00, "mask_after_reset");
    rd(3'd3, 8'h00, "cap_after_reset");
    rd(3'd0, 8'h0A, "data_after_reset");

`ifdef BIDIR_PIO_OPEN_DRAIN_EN
    // Open drain: bench stands in for pull-ups on released bits 7:4.
    tb_en  = 8'hF0;
    tb_val = 8'hF0;
    wr(3'd1, 8'hFF);
    wr(3'd0, 8'hF0);
    repeat (3) tick();
    chk("od_pins_low", {28'h0, pins[3:0]}, 32'h0);
    rd(3'd0, 8'hF0, "od_data_readback");
`endif

    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bidir_pio_ex.md
# bidir_pio_ex

Parametrised Avalon-MM slave bidirectional parallel I/O port, the multi-bit successor to the single-bit SDA/SCL bidir PIOs used for the SSD's I2C-style sideband lines. It provides WIDTH pins with per-bit direction control, a metastability-hardened input path, atomic bit set/clear of the output register, and per-bit edge capture with a maskable interrupt. Software bit-bangs serial protocols through it from the Nios-side Avalon fabric.

## Interface
- WIDTH, 8, number of pins (1..32)
- SYNC_STAGES, 2, input synchroniser depth (2..4)
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any
- RESET_OUT, 0, WIDTH-bit reset value of the output register
- RESET_DIR, 0, WIDTH-bit reset value of the direction register (1 = drive)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- read_n  in  1  active-low read strobe
- writedata  in  WIDTH  write data
- readdata  out  WIDTH  registered read data
- irq  out  1  level interrupt, active high
- bidir_port  inout  WIDTH  external pins

## Operation
- Register map (write = chipselect & ~write_n; read = chipselect & ~read_n):
  - 0 DATA: read = synchronised pin value; write loads data_out.
  - 1 DIR: read/write direction, bit 1 = pin driven.
  - 2 IRQMASK: read/write per-bit interrupt enable.
  - 3 EDGECAP: read capture bits; write 1 clears the corresponding bit, 0 leaves it.
  - 4 OUTSET: write ORs writedata into data_out; reads 0.
  - 5 OUTCLR: write clears data_out bits where writedata = 1; reads 0.
  - 6, 7: reads 0, writes ignored.
- Pin drive (push-pull): bit i = DIR[i] ? data_out[i] : Z.
- Input path: SYNC_STAGES flops per bit, then one "previous" flop; edge_i = per EDGE_TYPE from sync vs previous.
- Arm counter: after reset release, edge detection is disarmed for SYNC_STAGES+1 cycles so pins already high/low at reset produce no spurious capture; armed thereafter until next reset.
- EDGECAP[i] sets on armed edge_i; detected edge in the same cycle as a write-1-clear of that bit wins (bit stays/becomes 1).
- irq = |(EDGECAP & IRQMASK), combinational from registers, no glitch from address decode.
- Outputs driven as input are read back through the same synchroniser (loopback visible on DATA).

## Timing
- Reset values: readdata 0, irq 0, data_out RESET_OUT, DIR RESET_DIR, IRQMASK 0, EDGECAP 0, sync/previous flops 0, arm counter 0.
- Read latency 1: readdata updates on the clk edge after the read strobe; holds value otherwise.
- Writes take effect on the clk edge that samples the strobe; pin output changes that edge.
- Pin change to DATA visibility: SYNC_STAGES edges; to EDGECAP set: SYNC_STAGES+1 edges; irq same cycle as EDGECAP.
- Write of OUTSET/OUTCLR is single-cycle read-modify-write internally; back-to-back writes every cycle are legal.
- Reset assertion mid-operation: all registers return to reset values immediately, pins tri-state per RESET_DIR.

## Configuration
- BIDIR_PIO_OPEN_DRAIN_EN defined: pins are open-drain; bit i driven 0 when DIR[i] & ~data_out[i], else Z (data_out 1 releases the line). Required for shared I2C lines with external pull-ups.
- Undefined: push-pull drive as in Operation.

## Test plan
- Reset with pins held 0xA5, WIDTH 8 -> readdata 0, irq 0, EDGECAP reads 0x00 after arm window, DATA reads 0xA5.
- Write DIR=0x0F, DATA=0x3C, then OUTSET 0x81, OUTCLR 0x04 -> data_out 0xB9, pins low nibble 0x9, high nibble Z.
- EDGE_TYPE 0, IRQMASK=0x02, drive pin1 0->1 -> EDGECAP=0x02 after 3 edges (SYNC_STAGES 2), irq 1; write EDGECAP 0x02 -> irq 0 next cycle.
- Rising edge on pin3 coincident with write-1-clear of bit 3 -> EDGECAP[3] remains 1.
- Read address 6 -> readdata 0x00 one cycle later; read DIR -> written value.
- With BIDIR_PIO_OPEN_DRAIN_EN, DIR=0xFF, DATA=0xF0 -> pins 7:4 Z (pulled high), 3:0 driven 0; DATA reads 0xF0.
